// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: arbitrates memory freeze, taken-branch flush and load-use stall,
// with a data-memory wait watchdog. Define PIPE_STALL_STATS_EN to build the saturating stall statistics counters.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             dmem_valid,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] cnt_load_use,
    output logic [CNT_W-1:0] cnt_mem_wait,
    output logic [CNT_W-1:0] cnt_flush
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [8:0] WAIT_LIMIT = 9'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;
    logic [8:0] wait_inc;

    logic freeze;
    logic blocked;
    logic branch_cyc;
    logic load_use_cyc;

    // Request is withdrawn during reset so an abandoned access never reaches memory.
    assign dmem_valid   = rst_n && mem_access && (state_q != ST_ERROR);
    assign freeze       = dmem_valid && !dmem_ready;
    assign blocked      = freeze || (state_q == ST_ERROR);
    assign branch_cyc   = !blocked && branch_taken;
    assign load_use_cyc = !blocked && !branch_taken && load_use_stall;

    assign pc_en         = !blocked && !load_use_cyc;
    assign if_id_en      = !blocked && !load_use_cyc;
    assign id_ex_en      = !blocked;
    assign ex_mem_en     = !blocked;
    assign if_id_flush   = branch_cyc;
    assign id_ex_flush   = branch_cyc || load_use_cyc;
    assign mem_wb_bubble = blocked;
    assign mem_timeout   = mem_timeout_q;

    assign wait_inc = {1'b0, wait_cnt_q} + 9'd1;

    // Wait counter holds the number of consecutive freeze cycles seen so far.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    if (9'd1 >= WAIT_LIMIT) begin
                        state_d       = ST_ERROR;
                        mem_timeout_d = 1'b1;
                    end else begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = 8'd1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (freeze) begin
                    if (wait_inc >= WAIT_LIMIT) begin
                        state_d       = ST_ERROR;
                        mem_timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_inc[7:0];
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end
            end
            ST_ERROR: begin
                mem_timeout_d = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

`ifdef PIPE_STALL_STATS_EN
    logic [2:0]         stat_inc;
    logic [3*CNT_W-1:0] stat_all;

    // Slot order: 0 = load-use, 1 = memory freeze, 2 = branch flush.
    assign stat_inc = {branch_cyc, freeze, load_use_cyc};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (stat_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign stat_all[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate

    assign cnt_load_use = stat_all[0*CNT_W +: CNT_W];
    assign cnt_mem_wait = stat_all[1*CNT_W +: CNT_W];
    assign cnt_flush    = stat_all[2*CNT_W +: CNT_W];
`else
    assign cnt_load_use = '0;
    assign cnt_mem_wait = '0;
    assign cnt_flush    = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: directed scenarios then randomized traffic,
// each cycle's expected outputs come from a cycle-level behavioural model.
module tb_pipeline_stall_controller;

    localparam int TO = 4;
    localparam int CW = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          load_use_stall;
    logic          branch_taken;
    logic          mem_access;
    logic          dmem_ready;
    logic          dmem_valid;
    logic          pc_en;
    logic          if_id_en;
    logic          id_ex_en;
    logic          ex_mem_en;
    logic          if_id_flush;
    logic          id_ex_flush;
    logic          mem_wb_bubble;
    logic          mem_timeout;
    logic [CW-1:0] cnt_load_use;
    logic [CW-1:0] cnt_mem_wait;
    logic [CW-1:0] cnt_flush;

    pipeline_stall_controller #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_use_stall (load_use_stall),
        .branch_taken   (branch_taken),
        .mem_access     (mem_access),
        .dmem_ready     (dmem_ready),
        .dmem_valid     (dmem_valid),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .id_ex_en       (id_ex_en),
        .ex_mem_en      (ex_mem_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .mem_wb_bubble  (mem_wb_bubble),
        .mem_timeout    (mem_timeout),
        .cnt_load_use   (cnt_load_use),
        .cnt_mem_wait   (cnt_mem_wait),
        .cnt_flush      (cnt_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stage bits: {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble}
    typedef struct {
        logic          dv;
        logic          to;
        logic [6:0]    stage;
        logic [CW-1:0] clu;
        logic [CW-1:0] cmw;
        logic [CW-1:0] cfl;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model state: consecutive stalled memory cycles, error latch, event tallies.
    int   consec = 0;
    bit   err    = 1'b0;
    int   n_lu   = 0;
    int   n_mw   = 0;
    int   n_fl   = 0;

    function automatic logic [CW-1:0] stat_val(input int n);
`ifdef PIPE_STALL_STATS_EN
        return CW'((n > CNT_MAX) ? CNT_MAX : n);
`else
        return CW'(n * 0);
`endif
    endfunction

    task automatic drive(input bit rl, input bit ma, input bit rdy, input bit br, input bit lu);
        exp_t e;
        bit   valid;
        bit   frz;
        int   mode;
        @(posedge clk);
        #1;
        mem_access     = ma;
        dmem_ready     = rdy;
        branch_taken   = br;
        load_use_stall = lu;
        if (rl) begin
            #1;
            rst_n  = 1'b0;
            consec = 0;
            err    = 1'b0;
            n_lu   = 0;
            n_mw   = 0;
            n_fl   = 0;
        end else begin
            rst_n = 1'b1;
        end
        valid = !rl && ma && !err;
        frz   = valid && !rdy;
        // mode: 0 normal, 1 load-use, 2 branch, 3 held (freeze or error)
        if (err || frz)  mode = 3;
        else if (br)     mode = 2;
        else if (lu)     mode = 1;
        else             mode = 0;
        e.dv  = valid;
        e.to  = err;
        e.clu = stat_val(n_lu);
        e.cmw = stat_val(n_mw);
        e.cfl = stat_val(n_fl);
        case (mode)
            3:       e.stage = 7'b0000_001;
            2:       e.stage = 7'b1111_110;
            1:       e.stage = 7'b0011_010;
            default: e.stage = 7'b1111_000;
        endcase
        exp_q.push_back(e);
        if (!rl) begin
            if (frz)       n_mw++;
            if (mode == 2) n_fl++;
            if (mode == 1) n_lu++;
            if (!err) begin
                if (frz) begin
                    consec++;
                    if (consec >= TO) err = 1'b1;
                end else begin
                    consec = 0;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (vector %0d)", nm, act, req, vectors);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                $display("txn %0d t=%0t rst_n=%0b in{ma=%0b rdy=%0b br=%0b lu=%0b} dv=%0b stage=%07b to=%0b cnt=%0d/%0d/%0d",
                         vectors, $time, rst_n, mem_access, dmem_ready, branch_taken, load_use_stall,
                         dmem_valid, {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble},
                         mem_timeout, cnt_load_use, cnt_mem_wait, cnt_flush);
                chk("dmem_valid", 32'(dmem_valid), 32'(e.dv));
                chk("mem_timeout", 32'(mem_timeout), 32'(e.to));
                chk("stage_ctl", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble}),
                    32'(e.stage));
                chk("cnt_load_use", 32'(cnt_load_use), 32'(e.clu));
                chk("cnt_mem_wait", 32'(cnt_mem_wait), 32'(e.cmw));
                chk("cnt_flush", 32'(cnt_flush), 32'(e.cfl));
            end
        end
    end

    initial begin
        int rdy_pct;
        rst_n          = 1'b0;
        mem_access     = 1'b0;
        dmem_ready     = 1'b0;
        branch_taken   = 1'b0;
        load_use_stall = 1'b0;

        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 1);
        // lone load-use hazard
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        // three-cycle memory wait then completion
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0);
        // back-to-back access
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0);
        // freeze overrides branch and load-use; branch acts on completion
        drive(0, 1, 0, 1, 1);
        drive(0, 1, 1, 1, 0);
        // drop request mid-wait
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        // watchdog expiry and recovery by reset
        for (int i = 0; i < 7; i++) drive(0, 1, 0, 1, 0);
        drive(1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        // asynchronous reset in the middle of a wait
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 1, 0);
        drive(0, 1, 1, 0, 1);

        for (int i = 0; i < 1500; i++) begin
            rdy_pct = ((i / 100) % 3 == 0) ? 10 : 60;
            drive((i >= 1100) && ($urandom_range(0, 59) == 0),
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 99) < rdy_pct,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) == 0);
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, max consecutive MEM_WAIT cycles before error.
REQ-002 Parameter CNT_W, default 32, width of each stall statistics counter.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load_use_stall  input  1  load-use hazard request from the hazard detection unit.
REQ-006 branch_taken  input  1  taken branch/jump resolved in EX.
REQ-007 mem_access  input  1  EX/MEM instruction is a load or store.
REQ-008 dmem_ready  input  1  data memory accepts/completes the current access.
REQ-009 dmem_valid  output  1  access request to data memory.
REQ-010 pc_en, if_id_en, id_ex_en, ex_mem_en  output  1 each  stage register write enables.
REQ-011 if_id_flush, id_ex_flush, mem_wb_bubble  output  1 each  insert nop into IF/ID, ID/EX, MEM/WB.
REQ-012 mem_timeout  output  1  sticky error flag.
REQ-013 cnt_load_use, cnt_mem_wait, cnt_flush  output  CNT_W each  stall statistics (see Configuration).

Function
REQ-014 FSM states RUN, MEM_WAIT, ERROR; 2-bit state register, 8-bit wait counter.
REQ-015 dmem_valid = mem_access in RUN and MEM_WAIT; 0 in ERROR.
REQ-016 Handshake: access completes in the cycle dmem_valid && dmem_ready; dmem_valid held with mem_access until then.
REQ-017 freeze = dmem_valid && !dmem_ready; priority freeze > branch_taken > load_use_stall > normal.
REQ-018 freeze: pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_bubble = 1; both flushes = 0 (branch retained, acts after freeze).
REQ-019 branch (no freeze): all enables 1; if_id_flush = id_ex_flush = 1; load_use_stall ignored.
REQ-020 load-use (no freeze, no branch): pc_en = if_id_en = 0; id_ex_flush = 1; id_ex_en, ex_mem_en = 1.
REQ-021 normal: all enables 1, all flush/bubble 0.
REQ-022 Stage controls combinational from state and inputs; zero-cycle latency.
REQ-023 RUN -> MEM_WAIT on freeze; counter loads 1.
REQ-024 MEM_WAIT -> RUN when dmem_ready = 1 (completion cycle advances pipeline, no bubble); counter clears.
REQ-025 MEM_WAIT with freeze: counter increments; when counter reaches MEM_TIMEOUT, -> ERROR next edge.
REQ-026 MEM_WAIT with mem_access dropped: -> RUN, counter clears.
REQ-027 ERROR: mem_timeout = 1, pc_en/if_id_en/id_ex_en/ex_mem_en = 0, mem_wb_bubble = 1; exit only by reset.
REQ-028 Back-to-back accesses: completion followed by new mem_access next cycle re-enters freeze/MEM_WAIT normally.

Reset
REQ-029 rst_n low: state RUN, wait counter 0, mem_timeout 0, all statistics counters 0, immediately (asynchronous).
REQ-030 Reset mid-MEM_WAIT or in ERROR abandons the access; dmem_valid = 0 while rst_n low.

Configuration
REQ-031 Macro PIPE_STALL_STATS_EN defined: cnt_load_use +1 per REQ-020 cycle, cnt_mem_wait +1 per freeze cycle, cnt_flush +1 per REQ-019 cycle; all saturate at all-ones.
REQ-032 Macro undefined: no counter registers; cnt_* outputs tied to 0.

Verification
REQ-033 load_use_stall=1 one cycle, others 0 -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; cnt_load_use=1.
REQ-034 mem_access=1, dmem_ready=0 for 3 cycles then 1 -> 3 freeze cycles (mem_wb_bubble=1), state MEM_WAIT, 4th cycle all enables 1, state RUN.
REQ-035 freeze + branch_taken + load_use_stall together -> freeze outputs only; after dmem_ready=1 with branch_taken=1 -> if_id_flush=id_ex_flush=1.
REQ-036 MEM_TIMEOUT=4, dmem_ready held 0 -> ERROR after 4 wait cycles, mem_timeout=1, dmem_valid=0; rst_n pulse -> RUN, mem_timeout=0.
REQ-037 rst_n low during MEM_WAIT -> outputs reset asynchronously before next clk edge; counters 0.
